// File: rtl/ising_pkg.sv
// Shared definitions for the coupled phase oscillator cells of the Ising array.
// Provides:
//   - osc_state_e   : oscillator control states
//   - weight_value  : offset-coded weight code -> signed coupling value
//   - *_DEF         : default widths and bias for the weight and phase fields
package ising_pkg;

  localparam int WEIGHT_W_DEF    = 3;
  localparam int WEIGHT_BIAS_DEF = 2;
  localparam int PHASE_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SETTLED = 2'd2
  } osc_state_e;

  // Weight codes are stored offset-binary so that an all-zero-ish code can
  // express a negative (anti-ferromagnetic) coupling.
  function automatic int weight_value(input int code, input int bias);
    return code - bias;
  endfunction

endpackage

// File: rtl/osc_coupling_sum.sv
// Combinational coupling network for one oscillator.
// Decodes each neighbour weight, adds it to the adjustment when that
// neighbour's spin disagrees with ours, and turns BASE_STEP + adjustment into
// a phase step clamped to [1, 2*BASE_STEP].
// Ports:
//   coupling_weights  in  N*WEIGHT_W  weight j in bits [j*WEIGHT_W +: WEIGHT_W]
//   coupling_inputs   in  N           neighbour spins
//   out               in  1           this oscillator's registered spin
//   step              out STEP_W      clamped phase increment
//   adj_nz            out 1           raw adjustment is non-zero
module osc_coupling_sum
  import ising_pkg::*;
#(
  parameter int N           = 3,
  parameter int WEIGHT_W    = WEIGHT_W_DEF,
  parameter int WEIGHT_BIAS = WEIGHT_BIAS_DEF,
  parameter int BASE_STEP   = 4,
  parameter int STEP_W      = $clog2(2*BASE_STEP+1)
) (
  input  logic [N*WEIGHT_W-1:0] coupling_weights,
  input  logic [N-1:0]          coupling_inputs,
  input  logic                  out,
  output logic [STEP_W-1:0]     step,
  output logic                  adj_nz
);

  localparam int VAL_W  = WEIGHT_W + 1;
  // N signed terms of VAL_W bits each cannot overflow this width.
  localparam int SUM_W  = VAL_W + $clog2(N+1);
  // One extra bit over the wider operand so BASE_STEP + adj cannot wrap.
  localparam int CALC_W = ((SUM_W > STEP_W+1) ? SUM_W : STEP_W+1) + 1;

  logic signed [VAL_W-1:0]  val;
  logic signed [SUM_W-1:0]  adj;
  logic signed [CALC_W-1:0] raw;

  always_comb begin
    val = '0;
    adj = '0;
    for (int j = 0; j < N; j++) begin
      val = VAL_W'(weight_value(int'(coupling_weights[j*WEIGHT_W +: WEIGHT_W]), WEIGHT_BIAS));
      if (coupling_inputs[j] != out) begin
        adj = adj + SUM_W'(val);
      end
    end

    raw = CALC_W'(adj) + CALC_W'(BASE_STEP);

    // The step never stalls (>=1) and never exceeds twice nominal, which
    // bounds how fast a strongly coupled cell can be dragged along.
    if (raw < CALC_W'(1)) begin
      step = STEP_W'(1);
    end else if (raw > CALC_W'(2*BASE_STEP)) begin
      step = STEP_W'(2*BASE_STEP);
    end else begin
      step = STEP_W'(raw);
    end

    adj_nz = (adj != '0);
  end

endmodule

// File: rtl/coupled_phase_osc.sv
// Clocked coupled phase oscillator for the digital Ising array.
// A PHASE_W-bit accumulator advances by a coupling-dependent step each clock;
// its MSB is the spin. A settle detector counts consecutive periods in which
// the coupling adjustment stayed zero so the array controller can stop an
// anneal once every cell has locked.
// Ports:
//   clk               in  1           clock
//   rst               in  1           asynchronous active-high reset
//   run               in  1           1 = oscillate, 0 = return to IDLE
//   coupling_weights  in  N*WEIGHT_W  offset-coded neighbour weights
//   coupling_inputs   in  N           neighbour spins (same clock domain)
//   out               out 1           spin = registered phase MSB
//   phase             out PHASE_W     accumulator
//   period_tick       out 1           one-cycle pulse after each wrap
//   settled           out 1           high while in SETTLED
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | phase parked at INIT_PHASE, waiting for run
// ST_RUN     | oscillating, counting clean (zero-adjust) periods
// ST_SETTLED | oscillating, SETTLE_PERIODS clean periods seen, no adj since
module coupled_phase_osc
  import ising_pkg::*;
#(
  parameter int N              = 3,
  parameter int WEIGHT_W       = WEIGHT_W_DEF,
  parameter int WEIGHT_BIAS    = WEIGHT_BIAS_DEF,
  parameter int PHASE_W        = PHASE_W_DEF,
  parameter int BASE_STEP      = 4,
  parameter int INIT_PHASE     = 0,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [N*WEIGHT_W-1:0] coupling_weights,
  input  logic [N-1:0]          coupling_inputs,
  output logic                  out,
  output logic [PHASE_W-1:0]    phase,
  output logic                  period_tick,
  output logic                  settled
);

  localparam int STEP_W = $clog2(2*BASE_STEP+1);
  localparam int CNT_W  = $clog2(SETTLE_PERIODS+1);

  localparam logic [PHASE_W-1:0] INIT_P  = PHASE_W'(INIT_PHASE);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SETTLE_PERIODS);

  osc_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               out_q, out_d;
  logic               tick_q, tick_d;
  logic               settled_q, settled_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_q, flag_d;

  logic [STEP_W-1:0]  step;
  logic               adj_nz;
  logic [PHASE_W:0]   acc;
  logic               wrap;
  logic               flag_any;

  osc_coupling_sum #(
    .N           (N),
    .WEIGHT_W    (WEIGHT_W),
    .WEIGHT_BIAS (WEIGHT_BIAS),
    .BASE_STEP   (BASE_STEP),
    .STEP_W      (STEP_W)
  ) u_sum (
    .coupling_weights (coupling_weights),
    .coupling_inputs  (coupling_inputs),
    .out              (out_q),
    .step             (step),
    .adj_nz           (adj_nz)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    tick_d   = 1'b0;

    // Carry out of the extended sum marks the wrapping edge.
    acc      = {1'b0, phase_q} + (PHASE_W+1)'(step);
    wrap     = acc[PHASE_W];
    // Period activity including the current edge.
    flag_any = flag_q | adj_nz;

    case (state_q)
      ST_IDLE: begin
        phase_d = INIT_P;
        cnt_d   = '0;
        flag_d  = 1'b0;
        if (run) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
          phase_d = INIT_P;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end else begin
          phase_d = acc[PHASE_W-1:0];
          if (wrap) begin
            tick_d = 1'b1;
            flag_d = 1'b0;
            if (flag_any) begin
              cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            flag_d = flag_any;
          end
          // Count completed on the previous wrap; an adjustment right now
          // means the lock was lost before it could be reported.
          if (cnt_q == CNT_MAX) begin
            if (adj_nz) begin
              cnt_d = '0;
            end else begin
              state_d = ST_SETTLED;
            end
          end
        end
      end

      ST_SETTLED: begin
        if (!run) begin
          state_d = ST_IDLE;
          phase_d = INIT_P;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end else begin
          phase_d = acc[PHASE_W-1:0];
          tick_d  = wrap;
          flag_d  = wrap ? 1'b0 : flag_any;
          if (adj_nz) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = INIT_P;
        cnt_d   = '0;
        flag_d  = 1'b0;
      end
    endcase

    out_d     = phase_d[PHASE_W-1];
    settled_d = (state_d == ST_SETTLED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= INIT_P;
      out_q     <= INIT_P[PHASE_W-1];
      tick_q    <= 1'b0;
      settled_q <= 1'b0;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      settled_q <= settled_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
    end
  end

  assign out         = out_q;
  assign phase       = phase_q;
  assign period_tick = tick_q;
  assign settled     = settled_q;

endmodule

// File: tb/tb_coupled_phase_osc.sv
module tb_coupled_phase_osc;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       run_i;
  logic [8:0] weights;
  logic [2:0] inputs;

  logic       out, out_i;
  logic [7:0] phase, phase_i;
  logic       tick, tick_i;
  logic       settled, settled_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coupled_phase_osc #(
    .N(3), .WEIGHT_W(3), .WEIGHT_BIAS(2), .PHASE_W(8),
    .BASE_STEP(4), .INIT_PHASE(0), .SETTLE_PERIODS(4)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .coupling_weights(weights), .coupling_inputs(inputs),
    .out(out), .phase(phase), .period_tick(tick), .settled(settled)
  );

  coupled_phase_osc #(
    .N(3), .WEIGHT_W(3), .WEIGHT_BIAS(2), .PHASE_W(8),
    .BASE_STEP(4), .INIT_PHASE(128), .SETTLE_PERIODS(4)
  ) dut_i (
    .clk(clk), .rst(rst), .run(run_i),
    .coupling_weights(weights), .coupling_inputs(inputs),
    .out(out_i), .phase(phase_i), .period_tick(tick_i), .settled(settled_i)
  );

  typedef struct {
    logic [8:0] w;
    logic [2:0] in;
    int         k;
    int         exp_phase;
  } vec_t;

  vec_t vecs[9];

  localparam logic [8:0] W_ZERO = {3'b010, 3'b010, 3'b010};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    run     = 1'b0;
    run_i   = 1'b0;
    weights = W_ZERO;
    inputs  = 3'b000;
    #2;
    rst     = 1'b0;
  endtask

  int ticks;

  initial begin
    // weights written {w2, w1, w0}; out=0 throughout each vector
    vecs[0] = '{w: {3'b010, 3'b010, 3'b010}, in: 3'b000, k: 5,  exp_phase: 20};
    vecs[1] = '{w: {3'b010, 3'b010, 3'b100}, in: 3'b001, k: 5,  exp_phase: 30};
    vecs[2] = '{w: {3'b111, 3'b111, 3'b111}, in: 3'b111, k: 5,  exp_phase: 40};
    vecs[3] = '{w: {3'b000, 3'b000, 3'b000}, in: 3'b111, k: 5,  exp_phase: 5};
    vecs[4] = '{w: {3'b010, 3'b010, 3'b100}, in: 3'b000, k: 5,  exp_phase: 20};
    vecs[5] = '{w: {3'b001, 3'b011, 3'b111}, in: 3'b110, k: 3,  exp_phase: 12};
    vecs[6] = '{w: {3'b010, 3'b010, 3'b000}, in: 3'b001, k: 10, exp_phase: 20};
    vecs[7] = '{w: {3'b010, 3'b010, 3'b111}, in: 3'b001, k: 4,  exp_phase: 32};
    vecs[8] = '{w: {3'b010, 3'b000, 3'b101}, in: 3'b011, k: 6,  exp_phase: 30};

    // Reset values, sampled before the first clock edge
    rst = 1'b1; run = 1'b0; run_i = 1'b0; weights = W_ZERO; inputs = 3'b000;
    #2;
    check("rst_phase",   32'(phase), 0);
    check("rst_out",     32'(out), 0);
    check("rst_settled", 32'(settled), 0);
    check("rst_tick",    32'(tick), 0);
    check("rst_phase_init128", 32'(phase_i), 128);
    check("rst_out_init128",   32'(out_i), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // run=0 parks both cells
    step_n(100);
    check("idle_phase",         32'(phase), 0);
    check("idle_phase_init128", 32'(phase_i), 128);
    check("idle_tick",          32'(tick), 0);
    run_i = 1'b1;
    step_n(1);
    check("init128_start_edge", 32'(phase_i), 128);
    step_n(1);
    check("init128_first_inc",  32'(phase_i), 132);
    check("init128_out",        32'(out_i), 1);
    run_i = 1'b0;
    step_n(1);
    check("init128_abort",      32'(phase_i), 128);

    // Free run, period tick and settle detection
    do_reset();
    run = 1'b1;
    step_n(1);
    check("run_start_edge", 32'(phase), 0);
    step_n(31);
    check("fr_phase_31", 32'(phase), 124);
    check("fr_out_31",   32'(out), 0);
    step_n(1);
    check("fr_phase_32", 32'(phase), 128);
    check("fr_out_32",   32'(out), 1);
    step_n(31);
    check("fr_phase_63", 32'(phase), 252);
    check("fr_tick_63",  32'(tick), 0);
    step_n(1);
    check("fr_phase_64", 32'(phase), 0);
    check("fr_tick_64",  32'(tick), 1);
    check("fr_out_64",   32'(out), 0);
    step_n(1);
    check("fr_tick_65",  32'(tick), 0);
    check("fr_phase_65", 32'(phase), 4);
    ticks = 0;
    for (int i = 0; i < 191; i++) begin
      step_n(1);
      if (tick) ticks++;
    end
    check("fr_tick_count", 32'(ticks), 3);
    check("settle_tick4",   32'(tick), 1);
    check("settle_before",  32'(settled), 0);
    step_n(1);
    check("settle_rise",    32'(settled), 1);
    check("settle_phase",   32'(phase), 4);

    // Disturb: weight0 = +2 against a mismatched neighbour
    weights = {3'b010, 3'b010, 3'b100};
    inputs  = 3'b001;
    step_n(1);
    check("unsettle_fall",  32'(settled), 0);
    check("unsettle_phase", 32'(phase), 10);
    weights = W_ZERO;
    inputs  = 3'b000;
    step_n(318);
    check("resettle_early", 32'(settled), 0);
    step_n(1);
    check("resettle_rise",  32'(settled), 1);

    // Async reset while SETTLED, observed before the next edge
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_settled", 32'(settled), 0);
    check("async_rst_phase",   32'(phase), 0);
    check("async_rst_out",     32'(out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b0;

    // Positive coupling until out flips
    do_reset();
    weights = {3'b010, 3'b010, 3'b100};
    inputs  = 3'b001;
    run = 1'b1;
    step_n(1);
    step_n(21);
    check("pos_phase_21", 32'(phase), 126);
    check("pos_out_21",   32'(out), 0);
    step_n(1);
    check("pos_phase_22", 32'(phase), 132);
    check("pos_out_22",   32'(out), 1);
    step_n(1);
    check("pos_phase_23", 32'(phase), 136);

    // Abort mid-period and abort on a wrapping edge
    do_reset();
    run = 1'b1;
    step_n(1);
    step_n(25);
    check("abort_pre_phase", 32'(phase), 100);
    run = 1'b0;
    step_n(1);
    check("abort_phase",   32'(phase), 0);
    check("abort_tick",    32'(tick), 0);
    check("abort_settled", 32'(settled), 0);
    run = 1'b1;
    step_n(1);
    step_n(63);
    check("abortw_pre_phase", 32'(phase), 252);
    run = 1'b0;
    step_n(1);
    check("abortw_phase", 32'(phase), 0);
    check("abortw_tick",  32'(tick), 0);
    step_n(2);
    check("abortw_hold",  32'(phase), 0);

    // Step table: weight decode, masking and clamping
    for (int v = 0; v < 9; v++) begin
      do_reset();
      weights = vecs[v].w;
      inputs  = vecs[v].in;
      run = 1'b1;
      step_n(1);
      check($sformatf("vec%0d_start", v), 32'(phase), 0);
      step_n(vecs[v].k);
      check($sformatf("vec%0d_phase", v), 32'(phase), 32'(vecs[v].exp_phase));
      check($sformatf("vec%0d_out", v),   32'(out), 0);
      check($sformatf("vec%0d_tick", v),  32'(tick), 0);
    end
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
